// File: rtl/fpa_pipe.sv
// fpa_pipe: 3-stage IEEE add/sub with RNE, valid/ready handshake.
// Define FPA_FLAGS_EN to add the {invalid,overflow,underflow,inexact} port.
`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

module fpa_pipe #(
  parameter int EXP_SIZE = `EXP_SIZE,
  parameter int MANTIS_SIZE = `MANTIS_SIZE,
  localparam int W = 1 + EXP_SIZE + MANTIS_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] number_A,
  input  logic [W-1:0] number_B,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] number_out
`ifdef FPA_FLAGS_EN
  ,
  output logic [3:0]   flags
`endif
);
  localparam int E = EXP_SIZE;
  localparam int M = MANTIS_SIZE;
  localparam int F = M + 4;
  localparam int XW = 14;
  localparam logic signed [XW-1:0] EMAX = XW'((1 << E) - 1);
  localparam logic signed [XW-1:0] ZERO = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

  logic stall;
  logic a_s, b_s, a_z, b_z, a_i, b_i, a_n, b_n, swap, lost;
  logic [E-1:0] a_e, b_e, s_e;
  logic [M-1:0] a_m, b_m;
  logic [E+M-1:0] a_mag, b_mag;

  logic v1_d, s1_sign_d, s1_sub_d, s1_spec_d;
  logic v1_q, s1_sign_q, s1_sub_q, s1_spec_q;
  logic [E-1:0] s1_exp_d, s1_exp_q, diff;
  logic [F-1:0] s1_gm_d, s1_gm_q, s1_sm_d, s1_sm_q;
  logic [W-1:0] s1_sval_d, s1_sval_q;

  logic [F:0] sum;
  logic [XW-1:0] lzc;
  logic found;
  logic signed [XW-1:0] e_ext;
  logic v2_d, s2_sign_d, s2_spec_d;
  logic v2_q, s2_sign_q, s2_spec_q;
  logic signed [XW-1:0] s2_exp_d, s2_exp_q;
  logic [F-1:0] s2_man_d, s2_man_q;
  logic [W-1:0] s2_sval_d, s2_sval_q;

  logic g, r, st, rup, ovr;
  logic [M+1:0] rnd;
  logic signed [XW-1:0] ef;
  logic [M-1:0] frac;
  logic out_valid_d, out_valid_q;
  logic [W-1:0] number_out_d, number_out_q;

  assign stall = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign out_valid = out_valid_q;
  assign number_out = number_out_q;

  always_comb begin
    a_s = number_A[W-1];
    a_e = number_A[W-2 -: E];
    a_m = number_A[M-1:0];
    b_s = number_B[W-1] ^ op_sub;
    b_e = number_B[W-2 -: E];
    b_m = number_B[M-1:0];
    a_z = (a_e == '0);
    b_z = (b_e == '0);
    a_i = (a_e == '1) && (a_m == '0);
    b_i = (b_e == '1) && (b_m == '0);
    a_n = (a_e == '1) && (a_m != '0);
    b_n = (b_e == '1) && (b_m != '0);
    a_mag = a_z ? '0 : {a_e, a_m};
    b_mag = b_z ? '0 : {b_e, b_m};
    swap = b_mag > a_mag;
    v1_d = in_valid;
    s1_sub_d = a_s ^ b_s;
    s1_sign_d = swap ? b_s : a_s;
    s1_exp_d = swap ? b_e : a_e;
    s_e = swap ? a_e : b_e;
    s1_gm_d = swap ? {~b_z, b_mag[M-1:0], 3'b000}
                   : {~a_z, a_mag[M-1:0], 3'b000};
    s1_sm_d = swap ? {~a_z, a_mag[M-1:0], 3'b000}
                   : {~b_z, b_mag[M-1:0], 3'b000};
    diff = s1_exp_d - s_e;
    // every bit pushed past the sticky slot folds into it
    lost = |(s1_sm_d & ~({F{1'b1}} << diff));
    s1_sm_d = s1_sm_d >> diff;
    s1_sm_d[0] = s1_sm_d[0] | lost;
    s1_spec_d = 1'b1;
    s1_sval_d = '0;
    if (a_n || b_n || (a_i && b_i && s1_sub_d)) s1_sval_d = QNAN;
    else if (a_i) s1_sval_d = number_A;
    else if (b_i) s1_sval_d = {b_s, b_e, b_m};
    else if (a_z && b_z) s1_sval_d = {a_s & b_s, {(W-1){1'b0}}};
    else s1_spec_d = 1'b0;
  end

  always_comb begin
    sum = s1_sub_q ? ({1'b0, s1_gm_q} - {1'b0, s1_sm_q})
                   : ({1'b0, s1_gm_q} + {1'b0, s1_sm_q});
    lzc = '0;
    found = 1'b0;
    for (int i = F - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else lzc = lzc + XW'(1);
      end
    end
    e_ext = $signed({{(XW-E){1'b0}}, s1_exp_q});
    if (sum[F]) begin
      s2_man_d = {sum[F:2], sum[1] | sum[0]};
      s2_exp_d = e_ext + XW'(1);
    end else begin
      s2_man_d = sum[F-1:0] << lzc;
      s2_exp_d = e_ext - $signed(lzc);
    end
    // exact cancellation becomes a +0 special
    s2_spec_d = s1_spec_q || (sum == '0);
    s2_sval_d = s1_spec_q ? s1_sval_q : '0;
    s2_sign_d = s1_sign_q;
    v2_d = v1_q;
  end

  always_comb begin
    g = s2_man_q[2];
    r = s2_man_q[1];
    st = s2_man_q[0];
    rup = g & (r | st | s2_man_q[3]);
    rnd = {1'b0, s2_man_q[F-1:3]} + {{(M+1){1'b0}}, rup};
    ovr = rnd[M+1];
    ef = s2_exp_q + (ovr ? XW'(1) : XW'(0));
    frac = ovr ? rnd[M:1] : rnd[M-1:0];
    out_valid_d = v2_q;
    if (s2_spec_q) number_out_d = s2_sval_q;
    else if (ef <= ZERO) number_out_d = {s2_sign_q, {(W-1){1'b0}}};
    else if (ef >= EMAX) number_out_d = {s2_sign_q, {E{1'b1}}, {M{1'b0}}};
    else number_out_d = {s2_sign_q, ef[E-1:0], frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_sub_q <= 1'b0;
      s1_spec_q <= 1'b0;
      s1_exp_q <= '0;
      s1_gm_q <= '0;
      s1_sm_q <= '0;
      s1_sval_q <= '0;
      v2_q <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_spec_q <= 1'b0;
      s2_exp_q <= '0;
      s2_man_q <= '0;
      s2_sval_q <= '0;
      out_valid_q <= 1'b0;
      number_out_q <= '0;
    end else if (!stall) begin
      v1_q <= v1_d;
      s1_sign_q <= s1_sign_d;
      s1_sub_q <= s1_sub_d;
      s1_spec_q <= s1_spec_d;
      s1_exp_q <= s1_exp_d;
      s1_gm_q <= s1_gm_d;
      s1_sm_q <= s1_sm_d;
      s1_sval_q <= s1_sval_d;
      v2_q <= v2_d;
      s2_sign_q <= s2_sign_d;
      s2_spec_q <= s2_spec_d;
      s2_exp_q <= s2_exp_d;
      s2_man_q <= s2_man_d;
      s2_sval_q <= s2_sval_d;
      out_valid_q <= out_valid_d;
      number_out_q <= number_out_d;
    end
  end

`ifdef FPA_FLAGS_EN
  logic [3:0] flags_d, flags_q;
  assign flags = flags_q;

  always_comb begin
    flags_d = '0;
    if (s2_spec_q) begin
      flags_d[3] = (s2_sval_q[W-2:M] == '1) && s2_sval_q[M-1];
    end else begin
      flags_d[2] = ef >= EMAX;
      flags_d[1] = ef <= ZERO;
      flags_d[0] = g | r | st | flags_d[2] | flags_d[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else if (!stall) flags_q <= flags_d;
  end
`endif
endmodule
